dmem_responder: RTL and testbench

Data-memory responder for the single-cycle processor: the memory-side counterpart to the control unit's `MemRead`/`MemWrite` request.

- Accepts one load or store per handshake and holds the ALU-computed byte address, the RISC-V `funct3` width code and the store data.
- Performs the access on an internal byte-lane word array after a programmable number of wait states.
- Returns the sign- or zero-extended load result, or an error flag, with a single-cycle response pulse.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder:
// funct3 width codes and the responder state encoding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte write enables,
// synchronous write and combinational read on a shared index.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one load/store per handshake,
// waits WAIT_CYCLES, then performs the access and pulses rsp_valid.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t state, state_nxt;

    logic        cap_read;
    logic        cap_write;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  wait_cnt;

    logic        accept;
    logic        done;
    logic        bad_code;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] load_val;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready & (mem_read | mem_write);
    assign done      = (state == BUSY) && (wait_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (cap_read) begin
            bad_code = !(cap_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else begin
            bad_code = !(cap_f3 inside {F3_B, F3_H, F3_W});
        end
        misaligned = ((cap_f3[1:0] == 2'b01) && cap_addr[0])
                   || ((cap_f3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
        out_of_range = {2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS);
        fault = (cap_read & cap_write) | bad_code | misaligned | out_of_range;
    end

    assign lane_b = mem_rdata[8*cap_addr[1:0] +: 8];
    assign lane_h = cap_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (cap_f3)
            F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_val = {24'd0, lane_b};
            F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_val = {16'd0, lane_h};
            default: load_val = mem_rdata;
        endcase
    end

    // Lanes are replicated so the byte enables alone pick the target.
    always_comb begin
        be        = 4'b0000;
        mem_wdata = cap_wdata;
        case (cap_f3)
            F3_B: begin
                be        = 4'b0001 << cap_addr[1:0];
                mem_wdata = {4{cap_wdata[7:0]}};
            end
            F3_H: begin
                be        = cap_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{cap_wdata[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!(done && cap_write && !fault)) begin
            be = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
            cap_f3    <= 3'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            wait_cnt  <= 4'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                cap_read  <= mem_read;
                cap_write <= mem_write;
                cap_f3    <= funct3;
                cap_addr  <= addr;
                cap_wdata <= wdata;
                wait_cnt  <= 4'(WAIT_CYCLES);
            end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (done) begin
                err <= fault;
                if (cap_read && !fault) begin
                    rdata <= load_val;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (be),
        .idx  (cap_addr[AW+1:2]),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a
// byte-addressed reference memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n     [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        mem_read  [NI];
    logic        mem_write [NI];
    logic [2:0]  funct3    [NI];
    logic [31:0] addr      [NI];
    logic [31:0] wdata     [NI];
    logic        rsp_valid [NI];
    logic [31:0] rdata     [NI];
    logic        err       [NI];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mdl [NI][1024];
    logic [31:0] mrd [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(256),
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .mem_read (mem_read[g]),
            .mem_write(mem_write[g]),
            .funct3   (funct3[g]),
            .addr     (addr[g]),
            .wdata    (wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rdata    (rdata[g]),
            .err      (err[g])
        );
    end

    function automatic int wait_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access as little-endian bytes with plain arithmetic.
    function automatic void ref_acc(input int d, input logic mr,
            input logic mw, input logic [2:0] f3, input logic [31:0] a,
            input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int    sz;
        bit    legal;
        longint v;
        sz = 1 << f3[1:0];
        if (mr) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    legal = (f3 == 0 || f3 == 1 || f3 == 2);
        e = (mr && mw) || !legal || ((a % sz) != 0) || ((a / 4) >= 256);
        if (!e) begin
            if (mr) begin
                v = 0;
                for (int i = 0; i < sz; i++)
                    v = v + (longint'(mdl[d][a+i]) << (8 * i));
                if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1])
                    v = v - (longint'(1) << (8 * sz));
                mrd[d] = v[31:0];
            end else begin
                for (int i = 0; i < sz; i++)
                    mdl[d][a+i] = 8'(wd >> (8 * i));
            end
        end
        rd = mrd[d];
    endfunction

    task automatic run(input int d, input logic mr, input logic mw,
            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] erd;
        logic        ee;
        int          k;
        bit          got;
        ref_acc(d, mr, mw, f3, a, wd, ee, erd);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready[d]; i++) @(negedge clk);
        if (!req_ready[d]) chk("ready_wait", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        mem_read[d]  = mr;
        mem_write[d] = mw;
        funct3[d]    = f3;
        addr[d]      = a;
        wdata[d]     = wd;
        k   = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            k++;
            if (i == 0) begin
                req_valid[d] = 1'b0;
                mem_read[d]  = 1'($urandom);
                mem_write[d] = 1'($urandom);
                funct3[d]    = 3'($urandom);
                addr[d]      = $urandom;
                wdata[d]     = $urandom;
            end
            if (rsp_valid[d]) got = 1;
        end
        chk("rsp_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(wait_of(d) + 2));
        chk("err", 32'(err[d]), 32'(ee));
        chk("rdata", rdata[d], erd);
        @(negedge clk);
        chk("rsp_single", 32'(rsp_valid[d]), 32'd0);
    endtask

    task automatic check_reset(input int d);
        chk("rst_ready", 32'(req_ready[d]), 32'd1);
        chk("rst_rsp",   32'(rsp_valid[d]), 32'd0);
        chk("rst_rdata", rdata[d], 32'd0);
        chk("rst_err",   32'(err[d]), 32'd0);
    endtask

    initial begin
        int          acc, low, pulses, consec, cnt;
        logic        prev, e;
        logic [31:0] rd, na;
        logic [31:0] expq [$];
        logic        errq [$];

        for (int d = 0; d < NI; d++) begin
            rst_n[d] = 1'b0;     req_valid[d] = 1'b0;
            mem_read[d] = 1'b0;  mem_write[d] = 1'b0;
            funct3[d] = 3'd0;    addr[d] = 32'd0;
            wdata[d] = 32'd0;    mrd[d] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NI; d++) check_reset(d);
        for (int d = 0; d < NI; d++) rst_n[d] = 1'b1;

        for (int w = 0; w < 256; w++) run(0, 0, 1, F3_W, 32'(w * 4), $urandom);
        for (int w = 0; w < 8; w++)   run(1, 0, 1, F3_W, 32'(w * 4), $urandom);
        for (int w = 0; w < 16; w++)  run(2, 0, 1, F3_W, 32'(w * 4), $urandom);

        run(0, 0, 1, F3_W, 32'h10, 32'hDEADBEEF);
        run(0, 1, 0, F3_W, 32'h10, 32'd0);
        chk("lw_10", rdata[0], 32'hDEADBEEF);
        run(0, 0, 1, F3_B, 32'h13, 32'h80);
        run(0, 1, 0, F3_B, 32'h13, 32'd0);
        chk("lb_13", rdata[0], 32'hFFFFFF80);
        run(0, 1, 0, F3_BU, 32'h13, 32'd0);
        chk("lbu_13", rdata[0], 32'h00000080);
        run(0, 0, 1, F3_H, 32'h10, 32'h1234);
        run(0, 1, 0, F3_W, 32'h10, 32'd0);
        chk("lw_10_mix", rdata[0], 32'h80AD1234);
        run(0, 1, 0, F3_W, 32'h02, 32'd0);
        chk("lw_mis_err", 32'(err[0]), 32'd1);
        chk("lw_mis_rdata", rdata[0], 32'h80AD1234);
        run(0, 0, 1, F3_H, 32'h11, 32'hFFFF);
        chk("sh_mis_err", 32'(err[0]), 32'd1);
        run(0, 1, 0, F3_W, 32'h400, 32'd0);
        chk("lw_range_err", 32'(err[0]), 32'd1);
        run(0, 1, 0, 3'b011, 32'h10, 32'd0);
        chk("lw_f3_err", 32'(err[0]), 32'd1);
        run(0, 1, 1, F3_W, 32'h10, 32'h55555555);
        chk("both_err", 32'(err[0]), 32'd1);
        run(0, 1, 0, F3_W, 32'h10, 32'd0);
        chk("lw_10_keep", rdata[0], 32'h80AD1234);

        @(negedge clk);
        req_valid[0] = 1'b1; mem_read[0] = 1'b0; mem_write[0] = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (!req_ready[0] || rsp_valid[0]) cnt++;
        end
        req_valid[0] = 1'b0;
        chk("no_strobe_ignored", 32'(cnt), 32'd0);

        for (int t = 0; t < 300; t++) begin
            logic        mr, mw;
            logic [31:0] a;
            int          r;
            r  = $urandom_range(0, 9);
            mr = (r <= 5);
            mw = (r == 0) || (r >= 6);
            a  = 32'($urandom_range(0, 1151));
            if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
            run(0, mr, mw, 3'($urandom), a, $urandom);
        end

        @(negedge clk);
        acc = 0; low = 0; pulses = 0; consec = 0; prev = 1'b0;
        na = 32'h4;
        req_valid[1] = 1'b1; mem_read[1] = 1'b1; mem_write[1] = 1'b0;
        funct3[1] = F3_W;    addr[1] = na;
        for (int c = 0; c < 9; c++) begin
            bit taken;
            taken = req_ready[1];
            if (taken) begin
                acc++;
                ref_acc(1, 1, 0, F3_W, na, 32'd0, e, rd);
                expq.push_back(rd);
                errq.push_back(e);
            end else begin
                low++;
            end
            @(posedge clk);
            #1;
            if (taken) begin
                na = na + 32'd4;
                addr[1] = na;
            end
            @(negedge clk);
            if (rsp_valid[1]) begin
                pulses++;
                if (prev) consec++;
                if (expq.size() > 0) begin
                    chk("b2b_rdata", rdata[1], expq.pop_front());
                    chk("b2b_err", 32'(err[1]), 32'(errq.pop_front()));
                end else begin
                    chk("b2b_extra_rsp", 32'd1, 32'd0);
                end
            end
            prev = rsp_valid[1];
        end
        req_valid[1] = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_ready_low", 32'(low), 32'd6);
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_consec", 32'(consec), 32'd0);

        run(2, 0, 1, F3_W, 32'h20, 32'hA5A51234);
        run(2, 1, 0, F3_W, 32'h20, 32'd0);
        chk("rst_pre_lw", rdata[2], 32'hA5A51234);
        @(negedge clk);
        req_valid[2] = 1'b1; mem_read[2] = 1'b0; mem_write[2] = 1'b1;
        funct3[2] = F3_W;    addr[2] = 32'h20; wdata[2] = 32'hFFFFFFFF;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        #1 rst_n[2] = 1'b0;
        mrd[2] = 32'd0;
        #1 check_reset(2);
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[2]) cnt++;
        end
        chk("rst_no_rsp", 32'(cnt), 32'd0);
        run(2, 1, 0, F3_W, 32'h20, 32'd0);
        chk("rst_store_lost", rdata[2], 32'hA5A51234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
